// File: rtl/engine_batch_scheduler.sv
// engine_batch_scheduler: launches engine batches, drains results as a pixel stream, one frame per start_frame.
// Optional SCHED_PERF_CNT_EN adds saturating wait/stall performance counters.
module engine_batch_scheduler #(
  parameter int NUM_ENGINES   = 12,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int ITER_WIDTH    = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start_frame,
  output logic [NUM_ENGINES-1:0]                 engine_start,
  input  logic [NUM_ENGINES-1:0]                 engine_done,
  input  logic [NUM_ENGINES-1:0][ITER_WIDTH-1:0] engine_iter,
  output logic                                   fin_flag,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ITER_WIDTH-1:0]                  out_data,
  output logic                                   out_sop,
  output logic                                   out_eop,
  output logic                                   busy,
  output logic                                   frame_done
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                            perf_wait_cycles,
  output logic [31:0]                            perf_stall_cycles
`endif
);
  localparam int TOTAL = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int PW = $clog2(TOTAL + 1);
  localparam int IW = $clog2(NUM_ENGINES);
  localparam logic [PW-1:0] LAST = PW'(TOTAL - 1);
  localparam logic [PW-1:0] FULL = PW'(TOTAL);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_ENGINES - 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DRAIN, ADVANCE} state_t;
  state_t                                state;
  logic [NUM_ENGINES-1:0]                done_seen;
  logic [NUM_ENGINES-1:0][ITER_WIDTH-1:0] iter_q;
  logic [IW-1:0]                         idx;
  logic [PW-1:0]                         pix_cnt;
  // Outputs are registered, so the first pixel of a batch is forwarded from the capture path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done_seen <= '0;
      iter_q <= '0;
      idx <= '0;
      pix_cnt <= '0;
      engine_start <= '0;
      fin_flag <= 1'b0;
      frame_done <= 1'b0;
      busy <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
`ifdef SCHED_PERF_CNT_EN
      perf_wait_cycles <= '0;
      perf_stall_cycles <= '0;
`endif
    end else begin
      engine_start <= '0;
      fin_flag <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (start_frame) begin
          state <= LAUNCH;
          pix_cnt <= '0;
          engine_start <= '1;
          busy <= 1'b1;
`ifdef SCHED_PERF_CNT_EN
          perf_wait_cycles <= '0;
          perf_stall_cycles <= '0;
`endif
        end
        LAUNCH: begin
          done_seen <= '0;
          state <= WAIT;
        end
        WAIT: begin
          for (int i = 0; i < NUM_ENGINES; i++)
            if (engine_done[i] && !done_seen[i]) iter_q[i] <= engine_iter[i];
          done_seen <= done_seen | engine_done;
`ifdef SCHED_PERF_CNT_EN
          perf_wait_cycles <= perf_wait_cycles + {31'd0, ~&perf_wait_cycles};
`endif
          if (&(done_seen | engine_done)) begin
            state <= DRAIN;
            idx <= '0;
            out_valid <= 1'b1;
            out_data <= done_seen[0] ? iter_q[0] : engine_iter[0];
            out_sop <= pix_cnt == '0;
            out_eop <= pix_cnt == LAST;
          end
        end
        DRAIN: if (out_ready) begin
          pix_cnt <= pix_cnt + 1'b1;
          idx <= idx + 1'b1;
          out_sop <= 1'b0;
          if (idx == IDX_LAST || pix_cnt == LAST) begin
            state <= ADVANCE;
            out_valid <= 1'b0;
            out_data <= '0;
            out_eop <= 1'b0;
            fin_flag <= 1'b1;
            frame_done <= pix_cnt == LAST;
          end else begin
            out_data <= iter_q[idx + 1'b1];
            out_eop <= pix_cnt + 1'b1 == LAST;
          end
        end else begin
`ifdef SCHED_PERF_CNT_EN
          perf_stall_cycles <= perf_stall_cycles + {31'd0, ~&perf_stall_cycles};
`endif
        end
        ADVANCE: begin
          state <= pix_cnt == FULL ? IDLE : LAUNCH;
          engine_start <= {NUM_ENGINES{pix_cnt != FULL}};
          busy <= pix_cnt != FULL;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_engine_batch_scheduler.sv
// tb_engine_batch_scheduler: scoreboard bench with a behavioural engine model, NUM_ENGINES=3, 8x2 frame.
module tb_engine_batch_scheduler;
  logic clk = 0, reset = 1, start_frame = 0, out_ready = 1;
  logic [2:0] engine_start, engine_done = '0;
  logic [2:0][7:0] engine_iter = '0;
  logic fin_flag, out_valid, out_sop, out_eop, busy, frame_done;
  logic [7:0] out_data;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_wait_cycles, perf_stall_cycles;
`endif
  engine_batch_scheduler #(.NUM_ENGINES(3), .SCREEN_WIDTH(8), .SCREEN_HEIGHT(2), .ITER_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start_frame(start_frame), .engine_start(engine_start),
    .engine_done(engine_done), .engine_iter(engine_iter), .fin_flag(fin_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .busy(busy), .frame_done(frame_done)
`ifdef SCHED_PERF_CNT_EN
    , .perf_wait_cycles(perf_wait_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic [7:0] d; logic sop; logic eop;} pix_t;
  pix_t q[$];
  int tests = 0, fails = 0, fin_cnt = 0, fd_cnt = 0, npix = 0, mode = 0, t = 20;
  logic done_ok = 1, stalled = 0, hs = 0, he = 0;
  logic [7:0] hd = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Engine model: modes 0 plain, 1 backpressure, 2 out-of-order, 3 done-in-launch, 4 one stall per batch
  initial forever begin
    @(posedge clk); #1;
    if (engine_start[0]) t = 0; else if (t < 20) t++;
    engine_done = '0;
    if (mode == 2) begin
      if (t == 1) begin engine_done = 3'b100; engine_iter[2] = 8'd3; end
      if (t == 2) begin engine_done = 3'b001; engine_iter[0] = 8'd5; end
      if (t == 3) begin engine_done = 3'b001; engine_iter[0] = 8'd9; end
      if (t == 4) begin engine_done = 3'b010; engine_iter[1] = 8'd2; end
    end else if (mode == 3) begin
      if (t == 0) begin engine_done = '1; engine_iter = {8'd7, 8'd7, 8'd7}; end
      if (t == 4) begin engine_done = '1; engine_iter = {8'd3, 8'd2, 8'd1}; end
    end else if (t == 2) begin
      engine_done = '1; engine_iter = {8'd3, 8'd2, 8'd1};
    end
    done_ok = t >= ((mode == 2 || mode == 3) ? 5 : 3);
    out_ready = mode == 1 ? ~out_ready : mode == 4 ? (t != 3) : 1'b1;
  end
  // Monitor: pops the scoreboard on every accepted pixel
  initial forever begin
    @(negedge clk);
    if (reset) stalled = 0;
    else begin
      fin_cnt += int'(fin_flag);
      fd_cnt += int'(frame_done);
      if (out_valid) begin
        chk("drain_after_all_done", {31'd0, done_ok}, 1);
        if (stalled) chk("hold_stable", {22'd0, out_data, out_sop, out_eop}, {22'd0, hd, hs, he});
        if (out_ready) begin
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL extra_pixel: got data %0d expected no pixel", out_data);
          end else begin
            pix_t e;
            e = q.pop_front();
            chk("pixel_data", {24'd0, out_data}, {24'd0, e.d});
            chk("pixel_sop", {31'd0, out_sop}, {31'd0, e.sop});
            chk("pixel_eop", {31'd0, out_eop}, {31'd0, e.eop});
            npix++;
          end
        end
      end
      stalled = out_valid && !out_ready;
      hd = out_data; hs = out_sop; he = out_eop;
    end
  end
  task automatic pulse_start();
    @(posedge clk); #1 start_frame = 1;
    @(posedge clk); #1 start_frame = 0;
  endtask
  task automatic prep(input int m);
    logic [7:0] ev [3];
    mode = m;
    ev[0] = m == 2 ? 8'd5 : 8'd1; ev[1] = 8'd2; ev[2] = 8'd3;
    q.delete();
    for (int p = 0; p < 16; p++) q.push_back('{ev[p % 3], p == 0, p == 15});
    fin_cnt = 0; fd_cnt = 0; npix = 0;
  endtask
  task automatic run_frame(input int m);
    int c;
    prep(m);
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 1);
    for (c = 0; c < 500 && fd_cnt == 0; c++) begin
      @(posedge clk); #1 start_frame = (m == 1 && c == 10);
    end
    start_frame = 0;
    if (c == 500) begin tests++; fails++; $display("FAIL frame_timeout: got no frame_done expected one within 500 cycles"); end
    repeat (3) @(negedge clk);
    chk("fin_flag_count", fin_cnt, 6);
    chk("frame_done_count", fd_cnt, 1);
    chk("pixels_emitted", npix, 16);
    chk("scoreboard_empty", q.size(), 0);
    chk("idle_after_frame", {31'd0, busy}, 0);
`ifdef SCHED_PERF_CNT_EN
    if (m == 4) begin
      chk("perf_wait_cycles", perf_wait_cycles, 12);
      chk("perf_stall_cycles", perf_stall_cycles, 6);
    end
`endif
  endtask
  initial begin
    int c;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {18'd0, engine_start, fin_flag, out_valid, out_data, out_sop, out_eop, busy, frame_done}, 0);
`ifdef SCHED_PERF_CNT_EN
    chk("reset_perf", perf_wait_cycles | perf_stall_cycles, 0);
`endif
    @(posedge clk); #1 reset = 0;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(4);
    // Reset in the middle of draining aborts the frame
    prep(0);
    pulse_start();
    for (c = 0; c < 500 && npix < 5; c++) @(posedge clk);
    if (c == 500) begin tests++; fails++; $display("FAIL reset_wait_timeout: got %0d pixels expected 5", npix); end
    #1 reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_frame_reset_outputs", {18'd0, engine_start, fin_flag, out_valid, out_data, out_sop, out_eop, busy, frame_done}, 0);
    @(posedge clk); #1 reset = 0;
    repeat (5) @(negedge clk);
    chk("no_frame_done_after_reset", fd_cnt, 0);
    run_frame(0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
